// File: rtl/debounce_pkg.sv
// Shared constants, counter-width helper and event codes for the debounce bank.
package debounce_pkg;

  localparam int unsigned SYNC_STAGES = 2;

  // Bits needed to hold values 0..n, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

  typedef enum logic [1:0] {
    NONE = 2'd0,
    RISE = 2'd1,
    FALL = 2'd2,
    LONG = 2'd3
  } event_e;

  // Collapses one channel's pulses into a single code; long press wins.
  function automatic event_e event_code(input logic rise, input logic fall, input logic long_hit);
    if (long_hit)  return LONG;
    else if (rise) return RISE;
    else if (fall) return FALL;
    else           return NONE;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-FF synchroniser, tick-gated stability counter, edge pulses.
// Optional long-press hold counter under DEBOUNCE_BANK_LONG_PRESS_EN.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = 16,
  parameter int unsigned LONG_TICKS   = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_en,
  input  logic button_in,
  output logic button_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic long_press
);

  localparam int unsigned CNT_W = cnt_width(STABLE_TICKS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_TICKS - 1);

  if (STABLE_TICKS < 1 || LONG_TICKS <= STABLE_TICKS) begin : g_bad_params
    $error("debounce_channel: need STABLE_TICKS >= 1 and LONG_TICKS > STABLE_TICKS");
  end

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   sync1;

  assign sync1 = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync       <= '0;
      cnt        <= '0;
      button_out <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      sync       <= {sync[SYNC_STAGES-2:0], button_in};
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      if (tick_en) begin
        if (sync1 == button_out) begin
          cnt <= '0;
        end else if (cnt == CNT_MAX) begin
          button_out <= sync1;
          cnt        <= '0;
          rise_pulse <= sync1;
          fall_pulse <= ~sync1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef DEBOUNCE_BANK_LONG_PRESS_EN
  localparam int unsigned HOLD_W = cnt_width(LONG_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_TICKS);

  logic [HOLD_W-1:0] hold;

  // Saturation at HOLD_MAX is what limits the pulse to once per press.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold       <= '0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (!button_out) begin
        hold <= '0;
      end else if (tick_en && hold != HOLD_MAX) begin
        hold       <= hold + HOLD_W'(1);
        long_press <= (hold == HOLD_MAX - HOLD_W'(1));
      end
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel debouncer: CHANNELS independent debounce_channel instances sharing clk/rst/tick_en.
// Long-press pulses exist only when DEBOUNCE_BANK_LONG_PRESS_EN is defined.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned STABLE_TICKS = 16,
  parameter int unsigned LONG_TICKS   = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick_en,
  input  logic [CHANNELS-1:0] button_in,
  output logic [CHANNELS-1:0] button_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic [CHANNELS-1:0] long_press
);

  for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS (STABLE_TICKS),
      .LONG_TICKS   (LONG_TICKS)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .tick_en    (tick_en),
      .button_in  (button_in[i]),
      .button_out (button_out[i]),
      .rise_pulse (rise_pulse[i]),
      .fall_pulse (fall_pulse[i]),
      .long_press (long_press[i])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank: directed edge-timing scenarios plus randomized run vs a reference model.
module tb_debounce_bank;

  localparam int unsigned CH = 4;
  localparam int unsigned ST = 4;
  localparam int unsigned LT = 32;

  logic          clk;
  logic          rst;
  logic          tick_en;
  logic [CH-1:0] button_in;
  logic [CH-1:0] button_out, rise_pulse, fall_pulse, long_press;
  logic          b1_out, b1_rise, b1_fall, b1_long;

  int checks = 0;
  int errors = 0;

  debounce_bank #(
    .CHANNELS     (CH),
    .STABLE_TICKS (ST),
    .LONG_TICKS   (LT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_en    (tick_en),
    .button_in  (button_in),
    .button_out (button_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .long_press (long_press)
  );

  // Single-channel instance exercising the shortest stability window.
  debounce_bank #(
    .CHANNELS     (1),
    .STABLE_TICKS (1),
    .LONG_TICKS   (8)
  ) dut_st1 (
    .clk        (clk),
    .rst        (rst),
    .tick_en    (tick_en),
    .button_in  (button_in[0]),
    .button_out (b1_out),
    .rise_pulse (b1_rise),
    .fall_pulse (b1_fall),
    .long_press (b1_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1);
  end

  // Reference model: input seen two clocks late; level flips after ST consecutive
  // disagreeing ticks; hold time counted in ticks while the level is high.
  logic [CH-1:0] m_d1, m_d2, m_out, m_rise, m_fall, m_long;
  int m_run  [CH];
  int m_held [CH];

  task automatic model_step(input logic [CH-1:0] b, input logic t, input logic r);
    logic [CH-1:0] seen, prev;
    if (r) begin
      m_d1 = '0; m_d2 = '0; m_out = '0; m_rise = '0; m_fall = '0; m_long = '0;
      for (int i = 0; i < CH; i++) begin m_run[i] = 0; m_held[i] = 0; end
    end else begin
      seen = m_d2;
      prev = m_out;
      m_rise = '0; m_fall = '0; m_long = '0;
      for (int i = 0; i < CH; i++) begin
`ifdef DEBOUNCE_BANK_LONG_PRESS_EN
        if (!prev[i]) m_held[i] = 0;
        else if (t && m_held[i] < LT) begin
          m_held[i] = m_held[i] + 1;
          if (m_held[i] == LT) m_long[i] = 1'b1;
        end
`endif
        if (t) begin
          if (seen[i] != prev[i]) begin
            m_run[i] = m_run[i] + 1;
            if (m_run[i] == ST) begin
              m_out[i] = seen[i];
              m_run[i] = 0;
              if (seen[i]) m_rise[i] = 1'b1; else m_fall[i] = 1'b1;
            end
          end else m_run[i] = 0;
        end
      end
      m_d2 = m_d1;
      m_d1 = b;
    end
  endtask

  task automatic cycle(input logic [CH-1:0] b, input logic t, input logic r);
    button_in = b; tick_en = t; rst = r;
    @(posedge clk);
    model_step(b, t, r);
    @(negedge clk);
  endtask

  task automatic do_reset();
    for (int k = 0; k < 3; k++) cycle('0, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      cycle(4'hF, 1'b1, 1'b1);
      checks++;
      if ({button_out, rise_pulse, fall_pulse, long_press} !== 16'h0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: got %h want 0000", k,
                 {button_out, rise_pulse, fall_pulse, long_press});
      end
    end
    for (int e = 1; e <= 9; e++) begin
      cycle(4'hF, 1'b1, 1'b0);
      checks++;
      if (button_out !== ((e >= 6) ? 4'hF : 4'h0) || rise_pulse !== ((e == 6) ? 4'hF : 4'h0)
          || fall_pulse !== 4'h0) begin
        errors++;
        $display("FAIL reset_release edge%0d: got out=%h rise=%h fall=%h want out=%h rise=%h fall=0",
                 e, button_out, rise_pulse, fall_pulse,
                 (e >= 6) ? 4'hF : 4'h0, (e == 6) ? 4'hF : 4'h0);
      end
    end
  endtask

  task automatic test_clean_press();
    do_reset();
    for (int e = 1; e <= 20; e++) begin
      cycle(4'b0001, 1'b1, 1'b0);
      checks++;
      if (button_out !== ((e >= 6) ? 4'b0001 : 4'b0000) || rise_pulse !== ((e == 6) ? 4'b0001 : 4'b0000)
          || fall_pulse !== 4'b0000) begin
        errors++;
        $display("FAIL press edge%0d: got out=%h rise=%h fall=%h", e, button_out, rise_pulse, fall_pulse);
      end
    end
    for (int e = 1; e <= 10; e++) begin
      cycle(4'b0000, 1'b1, 1'b0);
      checks++;
      if (button_out !== ((e >= 6) ? 4'b0000 : 4'b0001) || fall_pulse !== ((e == 6) ? 4'b0001 : 4'b0000)
          || rise_pulse !== 4'b0000) begin
        errors++;
        $display("FAIL release edge%0d: got out=%h rise=%h fall=%h", e, button_out, rise_pulse, fall_pulse);
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    for (int k = 0; k < 13; k++) begin
      cycle((k < 3) ? 4'b0010 : 4'b0000, 1'b1, 1'b0);
      checks++;
      if ({button_out, rise_pulse, fall_pulse} !== 12'h0) begin
        errors++;
        $display("FAIL glitch_short cyc%0d: got out=%h rise=%h fall=%h want all 0",
                 k, button_out, rise_pulse, fall_pulse);
      end
    end
    // Bounce train 1,0,1,1,... ; edge 1 is the one sampling the last 0->1.
    for (int k = 0; k < 14; k++) begin
      int e;
      e = k - 1;
      cycle((k == 1) ? 4'b0000 : 4'b0010, 1'b1, 1'b0);
      checks++;
      if (button_out !== ((e >= 6) ? 4'b0010 : 4'b0000) || rise_pulse !== ((e == 6) ? 4'b0010 : 4'b0000)
          || fall_pulse !== 4'b0000) begin
        errors++;
        $display("FAIL bounce edge%0d: got out=%h rise=%h fall=%h", e, button_out, rise_pulse, fall_pulse);
      end
    end
  endtask

  task automatic test_tick_gating();
    int ticks;
    do_reset();
    ticks = 0;
    for (int c = 0; c < 30; c++) begin
      logic t;
      int   edge_no;
      t = (c % 3 == 2);
      edge_no = c + 1;
      cycle(4'b0001, t, 1'b0);
      if (t && edge_no >= 3) ticks++;
      checks++;
      if (button_out[0] !== (ticks >= 4) || rise_pulse[0] !== (t && edge_no >= 3 && ticks == 4)) begin
        errors++;
        $display("FAIL tick_gate edge%0d: got out=%b rise=%b want out=%b rise=%b", edge_no,
                 button_out[0], rise_pulse[0], ticks >= 4, t && edge_no >= 3 && ticks == 4);
      end
      checks++;
      if ({button_out, rise_pulse, fall_pulse, long_press} !== {m_out, m_rise, m_fall, m_long}) begin
        errors++;
        $display("FAIL tick_gate_model edge%0d: got %h want %h", edge_no,
                 {button_out, rise_pulse, fall_pulse, long_press}, {m_out, m_rise, m_fall, m_long});
      end
    end
  endtask

  task automatic test_reset_mid_count();
    do_reset();
    for (int k = 0; k < 4; k++) cycle(4'b0100, 1'b1, 1'b0);
    cycle(4'b0100, 1'b1, 1'b1);
    checks++;
    if ({button_out, rise_pulse} !== 8'h0) begin
      errors++;
      $display("FAIL mid_reset: got out=%h rise=%h want 0", button_out, rise_pulse);
    end
    for (int e = 1; e <= 8; e++) begin
      cycle(4'b0100, 1'b1, 1'b0);
      checks++;
      if (button_out !== ((e >= 6) ? 4'b0100 : 4'b0000) || rise_pulse !== ((e == 6) ? 4'b0100 : 4'b0000)) begin
        errors++;
        $display("FAIL mid_reset_requal edge%0d: got out=%h rise=%h", e, button_out, rise_pulse);
      end
    end
  endtask

  task automatic test_long_press();
    int pulses;
    pulses = 0;
    do_reset();
    for (int e = 1; e <= 80; e++) begin
      logic [CH-1:0] want;
      cycle(4'b1000, 1'b1, 1'b0);
`ifdef DEBOUNCE_BANK_LONG_PRESS_EN
      want = (e == 6 + LT) ? 4'b1000 : 4'b0000;
`else
      want = 4'b0000;
`endif
      if (long_press[3]) pulses++;
      checks++;
      if (long_press !== want) begin
        errors++;
        $display("FAIL long_press edge%0d: got %h want %h", e, long_press, want);
      end
    end
    for (int e = 1; e <= 10; e++) begin
      cycle(4'b0000, 1'b1, 1'b0);
      if (long_press[3]) pulses++;
    end
    checks++;
`ifdef DEBOUNCE_BANK_LONG_PRESS_EN
    if (pulses != 1) begin
`else
    if (pulses != 0) begin
`endif
      errors++;
      $display("FAIL long_press_count: got %0d pulses", pulses);
    end
  endtask

  task automatic test_stable_one();
    do_reset();
    for (int e = 1; e <= 5; e++) begin
      cycle(4'b0001, 1'b1, 1'b0);
      checks++;
      if (b1_out !== (e >= 3) || b1_rise !== (e == 3) || b1_fall !== 1'b0) begin
        errors++;
        $display("FAIL stable_one edge%0d: got out=%b rise=%b fall=%b want out=%b rise=%b",
                 e, b1_out, b1_rise, b1_fall, e >= 3, e == 3);
      end
    end
  endtask

  task automatic test_random();
    logic [CH-1:0] b;
    b = '0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic t, r;
      for (int i = 0; i < CH; i++)
        if ($urandom_range(0, 7) == 0) b[i] = ~b[i];
      t = (c < 1500) ? 1'b1 : ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 399) == 0);
      cycle(b, t, r);
      checks++;
      if ({button_out, rise_pulse, fall_pulse, long_press} !== {m_out, m_rise, m_fall, m_long}) begin
        errors++;
        $display("FAIL random cyc%0d: got %h want %h", c,
                 {button_out, rise_pulse, fall_pulse, long_press}, {m_out, m_rise, m_fall, m_long});
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    tick_en = 1'b1;
    button_in = '0;
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_glitch();
    test_tick_gating();
    test_reset_mid_count();
    test_long_press();
    test_stable_one();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
- Parametrised, multi-channel successor to the single-button shift-register debouncer.
- Each channel has:
  - a 2-FF synchroniser;
  - a programmable-length stability counter gated by a sample tick;
  - a registered clean level, plus one-cycle rise and fall pulses.
- Runs on the fast system clock; a divided tick replaces the separate slow clock.
- Feeds the button/switch consumers (FSMs, counters) that today need their own edge detectors.

Parameters:
- CHANNELS, 4: number of independent inputs; ≥1.
- STABLE_TICKS, 16: consecutive ticks an input must differ from the current level before the level flips; ≥1.
- LONG_TICKS, 1024: ticks the level must stay high before a long-press pulse fires. Used only with the optional feature; must be > STABLE_TICKS.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- tick_en  in  1  sample-enable strobe; 1-cycle pulses from a divider, or tied 1.
- button_in  in  CHANNELS  raw asynchronous inputs, bit i = channel i.
- button_out  out  CHANNELS  debounced levels.
- rise_pulse  out  CHANNELS  1-clk pulse when button_out[i] goes 0→1.
- fall_pulse  out  CHANNELS  1-clk pulse when button_out[i] goes 1→0.
- long_press  out  CHANNELS  1-clk pulse on a long hold (optional feature; otherwise constant 0).

Behaviour:
- Clocking and reset: one clock; synchronous active-high reset.
  - All state resets to 0 when rst is high at a posedge: sync FFs, counters, button_out, rise_pulse, fall_pulse, long_press.
  - rst dominates tick_en and button_in.
- Synchroniser: sync0 ← button_in and sync1 ← sync0 every clk, regardless of tick_en.
- Per-channel counter:
  - Width $clog2(STABLE_TICKS+1).
  - Updates only on cycles with tick_en=1.
  - If sync1 == button_out: cnt ← 0.
  - Else, if cnt == STABLE_TICKS-1: button_out ← sync1 and cnt ← 0. On the same edge, rise_pulse or fall_pulse ← 1, matching the new level.
  - Otherwise cnt ← cnt+1.
- Pulses:
  - rise_pulse and fall_pulse are registered and high for exactly one clk, even if tick_en is held.
  - They are cleared on the next edge.
  - A channel never asserts rise and fall together.
- Latency:
  - With tick_en=1 constantly, button_out changes on posedge number STABLE_TICKS+2.
  - Posedge 1 is the first edge that samples the new input value.
  - With a sparse tick, the change comes after STABLE_TICKS ticks counted from when sync1 first differs.
- Glitch rejection: any return of sync1 to the current level before the count completes clears the counter, with no output change.
- Tick gating: when tick_en=0, counters and button_out hold; pulses still self-clear.
- Channel independence: channels share only clk, rst and tick_en. Simultaneous transitions on several channels flip in the same cycle.
- Reset mid-count: the counter is discarded and button_out returns to 0. A button still held after reset re-qualifies from zero, and then produces a rise_pulse.
- STABLE_TICKS=1: the level flips on the first tick on which sync1 differs.

Optional Feature:
- Macro: DEBOUNCE_BANK_LONG_PRESS_EN.
- Defined:
  - Each channel adds a hold counter, width $clog2(LONG_TICKS+1), reset 0.
  - The counter increments on tick_en while button_out=1, saturating at LONG_TICKS.
  - It clears whenever button_out=0.
  - long_press[i] pulses for one clk on the tick where the counter reaches LONG_TICKS, once per press.
- Not defined: no hold counter is generated and long_press is driven constant 0. The port list is identical in both builds.

Decomposition:
- Package debounce_pkg holds:
  - SYNC_STAGES=2;
  - a function computing counter width (clog2 with a minimum of 1);
  - an enum for a per-channel event code (NONE, RISE, FALL, LONG) used by consumers.
- Sub-module debounce_channel: one channel (sync, stability counter, pulse regs, optional hold counter).
- The top generate-loops CHANNELS instances.

Test Plan:
- Reset: assert rst 3 cycles with button_in=4'hF → all outputs 0; after release, ch0–3 rise together on edge 6, each with rise_pulse high exactly 1 clk.
- Clean press (CHANNELS=4, STABLE_TICKS=4, tick_en=1): button_in[0] 0→1 held 20 cycles → button_out[0] rises on edge 6, rise_pulse[0] high 1 cycle. Release → fall_pulse[0] on edge 6 after release.
- Glitch rejection: button_in[1] high for 3 cycles, then low → button_out[1] stays 0, no pulses. Then a bounce train 1,0,1,1,1,1 → a single rise, on the 6th edge after the final 0→1.
- Tick gating: tick_en high every 3rd clk, STABLE_TICKS=4 → level flips after the 4th tick following sync1 change; pulse width still 1 clk.
- Reset mid-count: assert rst while cnt=2 on ch2 with input held high → button_out[2]=0 after rst; rise occurs STABLE_TICKS+2 edges after the rst deassert edge.
- Long press (macro defined, LONG_TICKS=32): hold ch3 for 60 ticks → exactly one long_press[3] pulse, 32 ticks after the rise. Macro undefined → long_press stays 0.
